// File: rtl/demux4way32_buf_pkg.sv
// Shared constants and types for the 4-way result demultiplexer.
// Covers lane count, select width, lane indices and occupancy states.
package demux4way32_buf_pkg;

   localparam int SEL_W = 2;
   localparam int LANES = 4;

   localparam logic [SEL_W-1:0] LANE0 = 2'd0;
   localparam logic [SEL_W-1:0] LANE1 = 2'd1;
   localparam logic [SEL_W-1:0] LANE2 = 2'd2;
   localparam logic [SEL_W-1:0] LANE3 = 2'd3;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_t;

   function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] s);
      logic [LANES-1:0] oh;
      oh = '0;
      case (s)
         LANE0:   oh = 4'b0001;
         LANE1:   oh = 4'b0010;
         LANE2:   oh = 4'b0100;
         LANE3:   oh = 4'b1000;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux4way32_buf_sel_fifo.sv
// In-order DEPTH-entry buffer of {sel,data} words with an explicit
// occupancy state machine driving the full/empty flags.
module sel_fifo
   import demux4way32_buf_pkg::*;
#(
   parameter int W     = SEL_W + 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] hd, tl;
   occ_t          state;
   logic          do_push, do_pop;

   // Guard here too, so a caller can never overrun or underrun the buffer.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign head  = mem[hd];
   assign full  = (state == OCC_FULL);
   assign empty = (state == OCC_EMPTY);

   always_ff @(posedge clk) begin
      if (do_push) mem[tl] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hd    <= '0;
         tl    <= '0;
         count <= '0;
         state <= OCC_EMPTY;
      end else begin
         if (do_push) tl <= tl + 1'b1;
         if (do_pop)  hd <= hd + 1'b1;
         unique case ({do_push, do_pop})
            2'b10: begin
               count <= count + 1'b1;
               state <= (count == CNT_FULL - 1'b1) ? OCC_FULL : OCC_PARTIAL;
            end
            2'b01: begin
               count <= count - 1'b1;
               state <= (count == CNT_ONE) ? OCC_EMPTY : OCC_PARTIAL;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/demux4way32_buf.sv
// Buffered 1-to-4 demux: routes each word to the lane named by its select,
// strictly in arrival order, holding the head until that lane is ready.
module demux4way32_buf
   import demux4way32_buf_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_valid,
   input  logic [LANES-1:0]       out_ready
);

   logic [SEL_W+WIDTH-1:0] head;
   logic [SEL_W-1:0]       head_sel;
   logic [WIDTH-1:0]       head_data;
   logic [$clog2(DEPTH):0] count;
   logic                   full, empty, push, pop;

   // No pass-through when full: a same-cycle pop only frees space next cycle.
   assign in_ready = ~full & ~reset;
   assign push     = in_valid & in_ready;
   assign pop      = ~empty & |(out_valid & out_ready);

   assign {head_sel, head_data} = head;

   sel_fifo #(.W(SEL_W + WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({in_sel, in_data}),
      .pop   (pop),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign out_valid = (count != '0) ? lane_onehot(head_sel) : '0;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign out_data[k*WIDTH +: WIDTH] = out_valid[k] ? head_data : '0;
   end

endmodule
